// File: rtl/logic_alu_seq.sv
// logic_alu_seq: valid/ready sequencing controller around a small logic ALU.
// AND/OR/XOR resolve in one cycle. SHR/SHL reuse a single 1-bit shifter
// iteratively, so a shift by s occupies s extra cycles in EXEC.
module logic_alu_seq #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         zero,
  output logic         err,
  output logic         busy
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] N_CNT = CW'(N);
  localparam logic [N-1:0]  N_B   = N'(N);
  localparam logic [CW-1:0] ONE   = CW'(1);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_SHR = 3'b011;
  localparam logic [2:0] OP_SHL = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_DONE
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [N-1:0]  acc;
  logic [CW-1:0] cnt;
  logic          shl_q;
  logic [CW-1:0] shift_amt;
  logic          is_shift;
  logic          illegal;
  logic [N-1:0]  idle_result;
  logic [N-1:0]  acc_shifted;

  // Decode the request: saturated shift distance, op class and the
  // single-cycle result (shift by zero passes a through unchanged).
  always_comb begin
    shift_amt   = '0;
    is_shift    = 1'b0;
    illegal     = 1'b0;
    idle_result = '0;
    if (b >= N_B) begin
      shift_amt = N_CNT;
    end else begin
      shift_amt = b[CW-1:0];
    end
    case (op)
      OP_AND:  idle_result = a & b;
      OP_OR:   idle_result = a | b;
      OP_XOR:  idle_result = a ^ b;
      OP_SHR, OP_SHL: begin
        is_shift    = 1'b1;
        idle_result = a;
      end
      default: illegal = 1'b1;
    endcase
  end

  // One bit position per EXEC cycle, zero fill in both directions.
  always_comb begin
    acc_shifted = '0;
    if (shl_q) begin
      acc_shifted = {acc[N-2:0], 1'b0};
    end else begin
      acc_shifted = {1'b0, acc[N-1:1]};
    end
  end

  // State register; reset abandons any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs. IDLE looks at in_valid directly since
  // in_ready is high throughout IDLE; DONE never accepts a new request.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          if (is_shift && (shift_amt != '0)) begin
            state_next = S_EXEC;
          end else begin
            state_next = S_DONE;
          end
        end
      end
      S_EXEC: begin
        if (cnt == ONE) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath: capture on accept, iterate in EXEC, hold everything in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      cnt    <= '0;
      shl_q  <= 1'b0;
      result <= '0;
      zero   <= 1'b1;
      err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            shl_q <= (op == OP_SHL);
            err   <= illegal;
            if (is_shift && (shift_amt != '0)) begin
              acc <= a;
              cnt <= shift_amt;
            end else begin
              result <= idle_result;
              zero   <= (idle_result == '0);
            end
          end
        end
        S_EXEC: begin
          acc <= acc_shifted;
          cnt <= cnt - ONE;
          if (cnt == ONE) begin
            result <= acc_shifted;
            zero   <= (acc_shifted == '0);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_logic_alu_seq.sv
// tb_logic_alu_seq: directed-vector bench for logic_alu_seq with N=4.
// Inputs are driven and outputs sampled 1ns after each rising edge.
module tb_logic_alu_seq;

  localparam int N = 4;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] result;
  logic         zero;
  logic         err;
  logic         busy;

  int checks;
  int failures;

  logic [N+4:0] status;
  assign status = {out_valid, in_ready, busy, err, zero, result};

  logic_alu_seq #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .err       (err),
    .busy      (busy)
  );

  // 10ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one request for exactly one edge; returns 1ns after the accept edge.
  task automatic do_accept(input logic [2:0] o, input logic [N-1:0] va, input logic [N-1:0] vb);
    in_valid = 1'b1;
    op       = o;
    a        = va;
    b        = vb;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op       = 3'b111;
    a        = 4'hF;
    b        = 4'hF;
  endtask

  // Count cycles from accept to first out_valid, bounded at 20.
  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  // Complete the output handshake with a single out_ready pulse.
  task automatic do_drain();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (status !== {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000}) begin
      failures++;
      $display("[TB] FAIL reset_state: got %b want %b", status, {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000});
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_release: got in_ready=%b busy=%b want 1 0", in_ready, busy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_logic();
    int lat;
    do_accept(3'b000, 4'b1100, 4'b1010);
    wait_out(lat);
    checks++;
    if (lat !== 1 || result !== 4'b1000 || zero !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL and_op: got lat=%0d result=%b zero=%b err=%b want 1 1000 0 0", lat, result, zero, err);
    end
    do_drain();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL and_drain: got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
    do_accept(3'b010, 4'b0110, 4'b0110);
    wait_out(lat);
    checks++;
    if (lat !== 1 || result !== 4'b0000 || zero !== 1'b1) begin
      failures++;
      $display("[TB] FAIL xor_zero: got lat=%0d result=%b zero=%b want 1 0000 1", lat, result, zero);
    end
    do_drain();
  endtask

  task automatic test_shift();
    int lat;
    do_accept(3'b100, 4'b0011, 4'd2);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({out_valid, in_ready, busy} !== 3'b001) begin
        failures++;
        $display("[TB] FAIL shl_exec%0d: got valid/ready/busy=%b want 001", i, {out_valid, in_ready, busy});
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if ({out_valid, in_ready, busy} !== 3'b101 || result !== 4'b1100 || zero !== 1'b0) begin
      failures++;
      $display("[TB] FAIL shl_done: got vrb=%b result=%b zero=%b want 101 1100 0", {out_valid, in_ready, busy}, result, zero);
    end
    do_drain();
    do_accept(3'b011, 4'b1011, 4'd1);
    wait_out(lat);
    checks++;
    if (lat !== 2 || result !== 4'b0101) begin
      failures++;
      $display("[TB] FAIL shr_by1: got lat=%0d result=%b want 2 0101", lat, result);
    end
    do_drain();
    do_accept(3'b100, 4'b0001, 4'd3);
    wait_out(lat);
    checks++;
    if (lat !== 4 || result !== 4'b1000) begin
      failures++;
      $display("[TB] FAIL shl_by3: got lat=%0d result=%b want 4 1000", lat, result);
    end
    do_drain();
    do_accept(3'b011, 4'b1000, 4'd0);
    wait_out(lat);
    checks++;
    if (lat !== 1 || result !== 4'b1000 || zero !== 1'b0) begin
      failures++;
      $display("[TB] FAIL shr_by0: got lat=%0d result=%b zero=%b want 1 1000 0", lat, result, zero);
    end
    do_drain();
  endtask

  task automatic test_reset_mid_exec();
    do_accept(3'b100, 4'b0001, 4'd3);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, busy, zero, err, result} !== {1'b0, 1'b0, 1'b1, 1'b0, 4'b0000}) begin
      failures++;
      $display("[TB] FAIL reset_mid_exec: got v/busy/zero/err/result=%b want 0010_0000", {out_valid, busy, zero, err, result});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_mid_release: got in_ready=%b busy=%b want 1 0", in_ready, busy);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
    end
    #1;
    checks++;
    if (out_valid !== 1'b0 || result !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL reset_discard: got out_valid=%b result=%b want 0 0000", out_valid, result);
    end
  endtask

  task automatic test_saturate();
    int lat;
    do_accept(3'b011, 4'b1111, 4'd9);
    wait_out(lat);
    checks++;
    if (lat !== 5 || result !== 4'b0000 || zero !== 1'b1) begin
      failures++;
      $display("[TB] FAIL shr_sat9: got lat=%0d result=%b zero=%b want 5 0000 1", lat, result, zero);
    end
    do_drain();
    do_accept(3'b100, 4'b1111, 4'd4);
    wait_out(lat);
    checks++;
    if (lat !== 5 || result !== 4'b0000 || zero !== 1'b1) begin
      failures++;
      $display("[TB] FAIL shl_by4: got lat=%0d result=%b zero=%b want 5 0000 1", lat, result, zero);
    end
    do_drain();
    do_accept(3'b100, 4'b0001, 4'd15);
    wait_out(lat);
    checks++;
    if (lat !== 5 || result !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL shl_sat15: got lat=%0d result=%b want 5 0000", lat, result);
    end
    do_drain();
  endtask

  task automatic test_illegal();
    int lat;
    do_accept(3'b001, 4'b0101, 4'b0000);
    wait_out(lat);
    do_drain();
    do_accept(3'b110, 4'b0101, 4'b0011);
    wait_out(lat);
    checks++;
    if (lat !== 1 || result !== 4'b0000 || err !== 1'b1 || zero !== 1'b1) begin
      failures++;
      $display("[TB] FAIL illegal_110: got lat=%0d result=%b err=%b zero=%b want 1 0000 1 1", lat, result, err, zero);
    end
    do_drain();
    do_accept(3'b001, 4'b0001, 4'b0010);
    wait_out(lat);
    checks++;
    if (result !== 4'b0011 || err !== 1'b0 || zero !== 1'b0) begin
      failures++;
      $display("[TB] FAIL or_after_err: got result=%b err=%b zero=%b want 0011 0 0", result, err, zero);
    end
    do_drain();
    do_accept(3'b111, 4'b1111, 4'b1111);
    wait_out(lat);
    checks++;
    if (result !== 4'b0000 || err !== 1'b1) begin
      failures++;
      $display("[TB] FAIL illegal_111: got result=%b err=%b want 0000 1", result, err);
    end
    do_drain();
  endtask

  task automatic test_backpressure();
    int lat;
    logic [N+4:0] want;
    do_accept(3'b000, 4'b1111, 4'b0101);
    wait_out(lat);
    want = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0101};
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      op       = i[2:0];
      a        = i[3:0];
      b        = ~i[3:0];
      @(posedge clk);
      #1;
      checks++;
      if (status !== want) begin
        failures++;
        $display("[TB] FAIL hold%0d: got %b want %b", i, status, want);
      end
    end
    in_valid  = 1'b1;
    op        = 3'b000;
    a         = 4'b0000;
    b         = 4'b0000;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++;
    if ({out_valid, in_ready, busy} !== 3'b010 || result !== 4'b0101) begin
      failures++;
      $display("[TB] FAIL bp_release: got vrb=%b result=%b want 010 0101", {out_valid, in_ready, busy}, result);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL bp_single_transfer: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    do_accept(3'b010, 4'b1010, 4'b0110);
    checks++;
    if (out_valid !== 1'b1 || result !== 4'b1100) begin
      failures++;
      $display("[TB] FAIL b2b_xor: got out_valid=%b result=%b want 1 1100", out_valid, result);
    end
    do_drain();
    do_accept(3'b011, 4'b1100, 4'd2);
    wait_out(lat);
    checks++;
    if (lat !== 3 || result !== 4'b0011) begin
      failures++;
      $display("[TB] FAIL b2b_shr: got lat=%0d result=%b want 3 0011", lat, result);
    end
    do_drain();
    do_accept(3'b001, 4'b1000, 4'b0100);
    checks++;
    if (out_valid !== 1'b1 || result !== 4'b1100 || err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL b2b_or: got out_valid=%b result=%b err=%b want 1 1100 0", out_valid, result, err);
    end
    do_drain();
  endtask

  // Run every scenario in order, then report.
  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op        = 3'b000;
    a         = '0;
    b         = '0;
    test_reset();
    test_logic();
    test_shift();
    test_reset_mid_exec();
    test_saturate();
    test_illegal();
    test_backpressure();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
